// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared layer/state types and the five-layer buffer map
package seq_pkg;

    typedef enum logic [2:0] {
        L_CONV0 = 3'd0,
        L_MAX1  = 3'd1,
        L_CONV2 = 3'd2,
        L_MAX3  = 3'd3,
        L_DENSE = 3'd4
    } layer_e;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_SCAN, S_FINISH, S_ERROR
    } state_e;

    typedef struct packed {
        logic [31:0] data_addr;
        logic [31:0] data_size;
        logic [31:0] weight_addr;
        logic [31:0] weight_size;
        logic [31:0] result_addr;
    } layer_desc_t;

    typedef struct packed {
        logic [31:0] img_base;
        logic [31:0] buf_a;
        logic [31:0] buf_b;
        logic [31:0] out_base;
        logic [31:0] w0_base;
        logic [31:0] w0_size;
        logic [31:0] w2_base;
        logic [31:0] w2_size;
        logic [31:0] w4_base;
        logic [31:0] w4_size;
    } mem_map_t;

    // Activations ping-pong between the two buffers; pooling layers carry no weights.
    function automatic layer_desc_t layer_desc(input layer_e layer, input mem_map_t map);
        layer_desc_t d;
        d = '0;
        case (layer)
            L_CONV0: d = '{map.img_base, 32'd1764, map.w0_base, map.w0_size, map.buf_a};
            L_MAX1:  d = '{map.buf_a,    32'd6400, 32'd0,       32'd0,       map.buf_b};
            L_CONV2: d = '{map.buf_b,    32'd1600, map.w2_base, map.w2_size, map.buf_a};
            L_MAX3:  d = '{map.buf_a,    32'd1296, 32'd0,       32'd0,       map.buf_b};
            L_DENSE: d = '{map.buf_b,    32'd324,  map.w4_base, map.w4_size, map.out_base};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - control-unit go/done handshake and result-memory read port
interface layer_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cu_go;
    logic [2:0]    cu_layer_index;
    logic [AW-1:0] cu_data_address;
    logic [AW-1:0] cu_data_size;
    logic [AW-1:0] cu_weight_address;
    logic [AW-1:0] cu_weight_size;
    logic [AW-1:0] cu_result_address;
    logic          cu_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;

    modport master (
        output cu_go, cu_layer_index, cu_data_address, cu_data_size,
               cu_weight_address, cu_weight_size, cu_result_address,
               mem_rd_en, mem_rd_addr,
        input  cu_done, mem_rd_data
    );

    modport slave (
        input  cu_go, cu_layer_index, cu_data_address, cu_data_size,
               cu_weight_address, cu_weight_size, cu_result_address,
               mem_rd_en, mem_rd_addr,
        output cu_done, mem_rd_data
    );
endinterface

// File: rtl/argmax_scanner.sv
// rtl/argmax_scanner.sv - reads ten scores and tracks the signed argmax
module argmax_scanner #(
    parameter int          AW   = 32,
    parameter int          DW   = 32,
    parameter int unsigned BASE = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          clear,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          done,
    output logic [3:0]    idx,
    output logic [DW-1:0] score
);
    logic                 rd_active;
    logic [3:0]           rd_cnt;
    logic                 dat_valid;
    logic [3:0]           dat_idx;
    logic [3:0]           best_idx;
    logic signed [DW-1:0] best_score;
    logic                 take;

    assign rd_en   = rd_active && !clear;
    assign rd_addr = rd_active ? AW'(BASE) + AW'(rd_cnt) : '0;

    // Strict compare keeps the lowest index on ties; word 0 always seeds the best.
    assign take  = dat_valid && ((dat_idx == 4'd0) || ($signed(rd_data) > best_score));
    assign done  = dat_valid && (dat_idx == 4'd9);
    assign idx   = take ? dat_idx : best_idx;
    assign score = take ? rd_data : best_score;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_active  <= 1'b0;
            rd_cnt     <= '0;
            dat_valid  <= 1'b0;
            dat_idx    <= '0;
            best_idx   <= '0;
            best_score <= '0;
        end else if (clear) begin
            rd_active <= 1'b0;
            dat_valid <= 1'b0;
        end else begin
            dat_valid <= rd_active;
            dat_idx   <= rd_cnt;
            if (start) begin
                rd_active <= 1'b1;
                rd_cnt    <= '0;
            end else if (rd_active) begin
                rd_cnt <= rd_cnt + 4'd1;
                if (rd_cnt == 4'd9) rd_active <= 1'b0;
            end
            if (take) begin
                best_idx   <= dat_idx;
                best_score <= $signed(rd_data);
            end
        end
    end
endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - five-layer go/done initiator with argmax readback
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int unsigned IMG_BASE = 0,
    parameter int unsigned BUF_A    = 2048,
    parameter int unsigned BUF_B    = 8704,
    parameter int unsigned OUT_BASE = 10240,
    parameter int unsigned W0_BASE  = 12288,
    parameter int unsigned W0_SIZE  = 40,
    parameter int unsigned W2_BASE  = 12352,
    parameter int unsigned W2_SIZE  = 148,
    parameter int unsigned W4_BASE  = 12544,
    parameter int unsigned W4_SIZE  = 3250,
    parameter int unsigned TIMEOUT  = 2000000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          net_done,
    output logic          error,
    output logic [3:0]    class_idx,
    output logic [DW-1:0] max_score,
    layer_sequencer_if.master bus
);
    localparam mem_map_t MAP = '{
        img_base: 32'(IMG_BASE), buf_a: 32'(BUF_A), buf_b: 32'(BUF_B),
        out_base: 32'(OUT_BASE), w0_base: 32'(W0_BASE), w0_size: 32'(W0_SIZE),
        w2_base: 32'(W2_BASE), w2_size: 32'(W2_SIZE),
        w4_base: 32'(W4_BASE), w4_size: 32'(W4_SIZE)
    };
    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state, state_next;
    layer_e        layer, layer_next;
    layer_desc_t   desc;
    logic [TW-1:0] tmo_cnt;
    logic          scan_start, scan_done;
    logic [3:0]    scan_idx;
    logic [DW-1:0] scan_score;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        layer_next = layer;
        case (state)
            S_IDLE, S_ERROR: if (start) begin
                state_next = S_ISSUE;
                layer_next = L_CONV0;
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (bus.cu_done)              state_next = S_NEXT;
                else if (tmo_cnt == TMO_LAST) state_next = S_ERROR;
            end
            S_NEXT: begin
                if (layer == L_DENSE) begin
                    state_next = S_SCAN;
                end else begin
                    state_next = S_ISSUE;
                    layer_next = layer_e'(layer + 3'd1);
                end
            end
            S_SCAN:   if (scan_done) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    // Layer arguments are captured only on entry to ISSUE so the control unit sees them stable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            layer     <= L_CONV0;
            desc      <= '0;
            tmo_cnt   <= '0;
            class_idx <= '0;
            max_score <= '0;
        end else begin
            if (state_next == S_ISSUE) begin
                layer <= layer_next;
                desc  <= layer_desc(layer_next, MAP);
            end
            if (state == S_ISSUE)     tmo_cnt <= '0;
            else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (state_next == S_FINISH) begin
                class_idx <= scan_idx;
                max_score <= scan_score;
            end
        end
    end

    assign scan_start = (state == S_NEXT) && (layer == L_DENSE) && !abort;

    assign busy     = (state != S_IDLE) && (state != S_ERROR);
    assign net_done = (state == S_FINISH);
    assign error    = (state == S_ERROR);

    assign bus.cu_go             = (state == S_ISSUE) && !abort;
    assign bus.cu_layer_index    = layer;
    assign bus.cu_data_address   = desc.data_addr[AW-1:0];
    assign bus.cu_data_size      = desc.data_size[AW-1:0];
    assign bus.cu_weight_address = desc.weight_addr[AW-1:0];
    assign bus.cu_weight_size    = desc.weight_size[AW-1:0];
    assign bus.cu_result_address = desc.result_addr[AW-1:0];

    argmax_scanner #(.AW(AW), .DW(DW), .BASE(OUT_BASE)) u_scan (
        .clk     (clk),
        .rstn    (rstn),
        .start   (scan_start),
        .clear   (abort),
        .rd_en   (bus.mem_rd_en),
        .rd_addr (bus.mem_rd_addr),
        .rd_data (bus.mem_rd_data),
        .done    (scan_done),
        .idx     (scan_idx),
        .score   (scan_score)
    );
endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - scoreboard bench for layer_sequencer
module tb_layer_sequencer;
    localparam int TIMEOUT  = 100;
    localparam int OUT_BASE = 10240;
    localparam int unsigned REF_DATA  [5] = '{0, 2048, 8704, 2048, 8704};
    localparam int unsigned REF_DSIZE [5] = '{1764, 6400, 1600, 1296, 324};
    localparam int unsigned REF_WADDR [5] = '{12288, 0, 12352, 0, 12544};
    localparam int unsigned REF_WSIZE [5] = '{40, 0, 148, 0, 3250};
    localparam int unsigned REF_RES   [5] = '{2048, 8704, 2048, 8704, 10240};

    logic        clk = 1'b0;
    logic        rstn, start, abort;
    logic        busy, net_done, error;
    logic [3:0]  class_idx;
    logic [31:0] max_score;

    layer_sequencer_if #(.AW(32), .DW(32)) bus ();

    layer_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .net_done  (net_done),
        .error     (error),
        .class_idx (class_idx),
        .max_score (max_score),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]  layer;
        logic [31:0] da, ds, wa, ws, ra;
    } go_t;
    typedef struct packed {
        logic [3:0]  cls;
        logic [31:0] score;
    } res_t;

    go_t         exp_go[$];
    logic [31:0] exp_rd[$];
    res_t        exp_res[$];

    int errors = 0;
    int checks = 0;
    logic signed [31:0] mem_words [10];
    int          cu_lat = 50;
    int          hang_layer = 7;
    int          last_done = -100;
    go_t         last_go = '0;
    logic [3:0]  last_cls = '0;
    logic [31:0] last_max = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Control-unit and result-memory model: observe at negedge, drive just after posedge.
    initial begin
        bit          go_s, rd_s;
        logic [2:0]  lay_s;
        int          ra_s, done_at;
        bus.cu_done = 1'b0;
        bus.mem_rd_data = '0;
        done_at = -1;
        forever begin
            @(negedge clk);
            go_s  = bus.cu_go;
            lay_s = bus.cu_layer_index;
            rd_s  = bus.mem_rd_en;
            ra_s  = int'(bus.mem_rd_addr) - OUT_BASE;
            if (!rstn) done_at = -1;
            else if (go_s && int'(lay_s) != hang_layer) done_at = cyc + cu_lat;
            @(posedge clk);
            #1;
            bus.cu_done = (cyc == done_at);
            if (rd_s && ra_s >= 0 && ra_s < 10) bus.mem_rd_data = mem_words[ra_s];
            else                                bus.mem_rd_data = $urandom;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents go, a read or net_done.
    initial begin
        go_t  cur, e;
        res_t r;
        logic [31:0] a;
        logic prev_nd;
        bit   busy_low_due;
        prev_nd = 1'b0;
        busy_low_due = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_nd = 1'b0;
                busy_low_due = 1'b0;
            end else begin
                cur = '{bus.cu_layer_index, bus.cu_data_address, bus.cu_data_size,
                        bus.cu_weight_address, bus.cu_weight_size, bus.cu_result_address};
                if (busy_low_due) begin
                    chk("busy_after_finish", busy, 0);
                    busy_low_due = 1'b0;
                end
                if (bus.cu_done) begin
                    last_done = cyc;
                    chk("args_stable", {cur.da, cur.ra}, {last_go.da, last_go.ra});
                end
                if (bus.cu_go) begin
                    chk("go_expected", exp_go.size() != 0, 1);
                    if (exp_go.size() != 0) begin
                        e = exp_go.pop_front();
                        chk("go_layer", cur.layer, e.layer);
                        chk("go_data", {cur.da, cur.ds}, {e.da, e.ds});
                        chk("go_weight", {cur.wa, cur.ws}, {e.wa, e.ws});
                        chk("go_result", cur.ra, e.ra);
                    end
                    chk("go_busy_error", {busy, error}, 2'b10);
                    if (cur.layer != 3'd0) chk("go_spacing", cyc - last_done, 2);
                    last_go = cur;
                end
                if (bus.mem_rd_en) begin
                    chk("rd_expected", exp_rd.size() != 0, 1);
                    if (exp_rd.size() != 0) begin
                        a = exp_rd.pop_front();
                        chk("rd_addr", bus.mem_rd_addr, a);
                    end
                end
                if (net_done) begin
                    chk("done_width", prev_nd, 0);
                    chk("finish_busy", busy, 1);
                    chk("res_expected", exp_res.size() != 0, 1);
                    if (exp_res.size() != 0) begin
                        r = exp_res.pop_front();
                        chk("class_idx", class_idx, r.cls);
                        chk("max_score", max_score, r.score);
                    end
                    busy_low_due = 1'b1;
                end
                prev_nd = net_done;
            end
        end
    end

    task automatic push_gos(input int n);
        for (int l = 0; l < n; l++)
            exp_go.push_back('{3'(l), REF_DATA[l], REF_DSIZE[l], REF_WADDR[l], REF_WSIZE[l], REF_RES[l]});
    endtask

    task automatic push_scan();
        int best;
        best = 0;
        for (int i = 0; i < 10; i++) exp_rd.push_back(32'(OUT_BASE + i));
        for (int i = 1; i < 10; i++) if (mem_words[i] > mem_words[best]) best = i;
        exp_res.push_back('{4'(best), mem_words[best]});
        last_cls = 4'(best);
        last_max = mem_words[best];
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_go(input int layer);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (bus.cu_go && bus.cu_layer_index == 3'(layer)) seen = 1'b1;
        end
        chk("wait_go", seen, 1);
    endtask

    task automatic wait_net_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (net_done) seen = 1'b1;
        end
        chk("wait_net_done", seen, 1);
    endtask

    task automatic check_drained();
        chk("go_drained", exp_go.size(), 0);
        chk("rd_drained", exp_rd.size(), 0);
        chk("res_drained", exp_res.size(), 0);
    endtask

    task automatic random_scores(input bit narrow);
        for (int i = 0; i < 10; i++)
            if (narrow) mem_words[i] = $signed($urandom_range(0, 6)) - 3;
            else        mem_words[i] = $urandom;
    endtask

    task automatic run_pass(input bit poke_l1);
        push_gos(5);
        push_scan();
        pulse_start();
        if (poke_l1) begin
            wait_go(1);
            repeat (5) @(posedge clk);
            #1 start = 1'b1;
            repeat (3) @(posedge clk);
            #1 start = 1'b0;
        end
        wait_net_done();
        repeat (2) @(negedge clk);
        check_drained();
    endtask

    initial begin
        bit seen;
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", {busy, net_done, error}, 3'b000);
        chk("rst_result", {class_idx, max_score}, 36'h0);
        chk("rst_go", {bus.cu_go, bus.cu_layer_index}, 4'h0);
        chk("rst_data", {bus.cu_data_address, bus.cu_data_size}, 64'h0);
        chk("rst_weight", {bus.cu_weight_address, bus.cu_weight_size}, 64'h0);
        chk("rst_rd", {bus.mem_rd_en, bus.mem_rd_addr, bus.cu_result_address}, 65'h0);
        rstn = 1'b1;

        mem_words = '{-5, 3, 9, -1, 9, 0, 2, 2, 8, 7};
        cu_lat = 50;
        run_pass(1'b1);

        mem_words = '{-9, -8, -7, -6, -5, -4, -3, -1, -2, -9};
        cu_lat = $urandom_range(1, 60);
        run_pass(1'b0);

        for (int p = 0; p < 6; p++) begin
            random_scores(p[0]);
            cu_lat = $urandom_range(1, 60);
            run_pass(1'b0);
        end

        hang_layer = 2;
        cu_lat = $urandom_range(1, 40);
        push_gos(3);
        pulse_start();
        wait_go(2);
        repeat (TIMEOUT) @(negedge clk);
        chk("pre_timeout", {busy, error}, 2'b10);
        @(negedge clk);
        chk("timeout_error", {busy, error}, 2'b01);
        repeat (10) @(negedge clk);
        chk("error_sticky", {busy, error}, 2'b01);
        chk("timeout_go_drained", exp_go.size(), 0);
        hang_layer = 7;
        random_scores(1'b1);
        run_pass(1'b0);

        cu_lat = 50;
        push_gos(4);
        pulse_start();
        wait_go(3);
        repeat (50) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_status", {busy, error, net_done}, 3'b000);
        chk("abort_class", class_idx, last_cls);
        chk("abort_score", max_score, last_max);
        check_drained();

        random_scores(1'b0);
        cu_lat = $urandom_range(1, 30);
        push_gos(5);
        push_scan();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en) seen = 1'b1;
        end
        chk("wait_scan", seen, 1);
        repeat (3) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("arst_status", {busy, net_done, error}, 3'b000);
        chk("arst_result", {class_idx, max_score}, 36'h0);
        chk("arst_rd", {bus.mem_rd_en, bus.mem_rd_addr}, 33'h0);
        chk("arst_go", {bus.cu_go, bus.cu_layer_index, bus.cu_result_address}, 36'h0);
        chk("arst_data", {bus.cu_data_address, bus.cu_weight_size}, 64'h0);
        exp_go.delete();
        exp_rd.delete();
        exp_res.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        random_scores(1'b1);
        cu_lat = $urandom_range(1, 60);
        run_pass(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Initiator side of the accelerator's go/done layer handshake. Runs the full five-layer MNIST pass (conv, max, conv, max, dense) by issuing one go pulse per layer with layer index, buffer addresses and sizes, then waiting for done.
- After the dense layer, reads the 10 class scores back from result memory and reports the signed argmax.
- Sits between the host start/status registers and the control unit.

Parameters:
- AW, 32, address/size width
- DW, 32, score word width (signed)
- IMG_BASE, 0, input image (42x42) base
- BUF_A, 2048, ping buffer base
- BUF_B, 8704, pong buffer base
- OUT_BASE, 10240, dense output base (10 words)
- W0_BASE/W0_SIZE, 12288/40, layer-0 weights+biases
- W2_BASE/W2_SIZE, 12352/148, layer-2 weights+biases
- W4_BASE/W4_SIZE, 12544/3250, dense weights+biases
- TIMEOUT, 2000000, max cycles waiting for one layer done

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  begin a pass (level, sampled in IDLE/ERROR)
- abort  in  1  synchronous abort to IDLE
- busy  out  1  pass in progress
- net_done  out  1  one-cycle pulse at pass completion
- error  out  1  sticky layer timeout flag
- class_idx  out  4  argmax class 0..9
- max_score  out  DW  winning score
- cu_go  out  1  one-cycle layer start pulse
- cu_layer_index  out  3  layer 0..4
- cu_data_address / cu_data_size  out  AW  layer input base/word count
- cu_weight_address / cu_weight_size  out  AW  layer weight base/word count (0 for max layers)
- cu_result_address  out  AW  layer output base
- cu_done  in  1  layer complete pulse
- mem_rd_en  out  1  result memory read strobe
- mem_rd_addr  out  AW  read address
- mem_rd_data  in  DW  read data, valid exactly 1 cycle after mem_rd_en

Behaviour:
- Reset: state IDLE; every output 0 (class_idx 0, max_score 0, all cu_* 0).
- States: IDLE, ISSUE, WAIT, NEXT, SCAN, FINISH, ERROR.
- IDLE: start=1 -> ISSUE, layer=0, busy=1, error cleared.
- ISSUE (1 cycle): cu_go=1. cu_* argument outputs are registered and change only on entry to ISSUE; they are held stable until the next ISSUE. Timeout counter cleared. -> WAIT.
- Layer map (data -> result, size in/out):
  - L0: IMG_BASE -> BUF_A, 1764
  - L1: BUF_A -> BUF_B, 6400
  - L2: BUF_B -> BUF_A, 1600
  - L3: BUF_A -> BUF_B, 1296
  - L4: BUF_B -> OUT_BASE, 324
- WAIT: counter +1 per cycle.
  - cu_done=1 -> NEXT.
  - counter==TIMEOUT-1 without done -> ERROR.
  - cu_done sampled in any state other than WAIT is ignored.
- NEXT (1 cycle): if layer<4, layer+1 and -> ISSUE. The next cu_go therefore rises exactly 2 cycles after cu_done is sampled. If layer==4 -> SCAN.
- SCAN: mem_rd_en=1 for 10 consecutive cycles, addr OUT_BASE+0..9.
  - Each returning word is compared signed; strictly greater replaces the best, so ties keep the lowest index.
  - Word 0 initialises the best unconditionally.
  - After the 10th data cycle -> FINISH; SCAN takes 11 cycles.
- FINISH (1 cycle): net_done=1; class_idx/max_score updated this cycle and held until the next pass completes. busy=0 next cycle. -> IDLE.
- ERROR: busy=0, error=1, cu_go=0. start -> restart at layer 0 (error cleared). abort -> IDLE (error cleared).
- abort=1 in any state: next state IDLE, cu_go=0, mem_rd_en=0, busy=0, scan discarded. abort has priority over start and cu_done in the same cycle.
- start while busy is ignored. Reset mid-pass returns immediately to reset values.

Decomposition:
- Shared package seq_pkg:
  - layer enum (L_CONV0..L_DENSE, 3 bits)
  - layer descriptor struct {data_addr, data_size, weight_addr, weight_size, result_addr}
  - constant function returning the descriptor for a layer index
  - state enum
- Sub-module argmax_scanner: read issue, 1-cycle-latency compare pipeline, start/done, outputs idx and score.

Test Plan:
- Full pass, cu model returns done 50 cycles after each go -> exactly 5 go pulses, layer_index 0..4, addresses/sizes per the layer map, each go 2 cycles after done; 10 reads at OUT_BASE..OUT_BASE+9.
- Scores {-5,3,9,-1,9,0,2,2,8,7} -> class_idx=2, max_score=9, net_done one cycle. All negative {-9..-1 with -1 at index 7} -> class_idx=7.
- TIMEOUT=100, cu model never responds at L2 -> error=1 after 100 WAIT cycles, busy=0; start again -> go with layer_index=0, error=0.
- abort asserted mid-WAIT of L3 in the same cycle as cu_done -> IDLE, no further go, busy=0, class_idx unchanged.
- start pulsed during L1 WAIT -> no extra go; async rstn low mid-SCAN -> all outputs 0 immediately.
